// File: rtl/lif_spike_generator.sv
// lif_spike_generator: leaky integrate-and-fire neuron with a valid/ready sample input and a refractory period
// counted in samples. Each accepted sample yields exactly one registered spk_valid strobe two cycles later.
module lif_spike_generator #(
    parameter logic [7:0] THRESHOLD      = 8'd128,
    parameter int         LEAK_SHIFT     = 3,
    parameter int         REFRACT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pot_valid,
    input  logic [7:0] pot_in,
    output logic       pot_ready,
    output logic       spk_valid,
    output logic       spk_out,
    output logic [7:0] membrane,
    output logic [7:0] spike_count
);
    typedef enum logic [1:0] {IDLE, UPDATE, REFRACT, DRAIN} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_sample, w_sample_nxt;
    logic [7:0]  r_membrane, w_membrane_nxt;
    logic [3:0]  r_refract, w_refract_nxt;
    logic [7:0]  r_count, w_count_nxt;
    logic        r_spk_valid, w_spk_valid_nxt;
    logic        r_spk_out, w_spk_out_nxt;
    logic [7:0]  w_leak;
    logic [8:0]  w_sum;
    logic [7:0]  w_next;
    logic        w_fire;

    // The leak never exceeds the membrane, so the 9-bit sum cannot underflow
    assign w_leak = (LEAK_SHIFT == 0) ? 8'd0 : (r_membrane >> LEAK_SHIFT);
    assign w_sum  = {1'b0, r_membrane} - {1'b0, w_leak} + {1'b0, r_sample};
    assign w_next = w_sum[8] ? 8'hFF : w_sum[7:0];
    assign w_fire = (w_next >= THRESHOLD);

    // Ready comes from the state register alone; reset only masks it
    assign pot_ready   = !reset && (r_state == IDLE || r_state == REFRACT);
    assign spk_valid   = r_spk_valid;
    assign spk_out     = r_spk_out;
    assign membrane    = r_membrane;
    assign spike_count = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sample    <= 8'd0;
            r_membrane  <= 8'd0;
            r_refract   <= 4'd0;
            r_count     <= 8'd0;
            r_spk_valid <= 1'b0;
            r_spk_out   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sample    <= w_sample_nxt;
            r_membrane  <= w_membrane_nxt;
            r_refract   <= w_refract_nxt;
            r_count     <= w_count_nxt;
            r_spk_valid <= w_spk_valid_nxt;
            r_spk_out   <= w_spk_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sample_nxt    = r_sample;
        w_membrane_nxt  = r_membrane;
        w_refract_nxt   = r_refract;
        w_count_nxt     = r_count;
        w_spk_valid_nxt = 1'b0;
        w_spk_out_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (pot_valid) begin
                    w_sample_nxt = pot_in;
                    w_state_nxt  = UPDATE;
                end
            end
            UPDATE: begin
                w_spk_valid_nxt = 1'b1;
                if (w_fire) begin
                    w_membrane_nxt = 8'd0;
                    w_spk_out_nxt  = 1'b1;
                    w_count_nxt    = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
                    w_refract_nxt  = 4'(REFRACT_CYCLES);
                    w_state_nxt    = (REFRACT_CYCLES == 0) ? IDLE : REFRACT;
                end else begin
                    w_membrane_nxt = w_next;
                    w_state_nxt    = IDLE;
                end
            end
            REFRACT: begin
                if (pot_valid) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                w_membrane_nxt  = 8'd0;
                w_spk_valid_nxt = 1'b1;
                w_refract_nxt   = r_refract - 4'd1;
                w_state_nxt     = (r_refract == 4'd1) ? IDLE : REFRACT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lif_spike_generator.sv
// tb_lif_spike_generator: scoreboard bench for three neuron configurations
// (default, THRESHOLD=255, REFRACT_CYCLES=0) sharing one clock and reset.
module tb_lif_spike_generator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       v[3];
    logic [7:0] pi[3];
    logic       rdy[3], sv[3], so[3];
    logic [7:0] mem[3], cnt[3];

    lif_spike_generator #(.THRESHOLD(8'd128), .LEAK_SHIFT(3), .REFRACT_CYCLES(2)) u0 (
        .clk(clk), .reset(reset), .pot_valid(v[0]), .pot_in(pi[0]), .pot_ready(rdy[0]),
        .spk_valid(sv[0]), .spk_out(so[0]), .membrane(mem[0]), .spike_count(cnt[0]));
    lif_spike_generator #(.THRESHOLD(8'd255), .LEAK_SHIFT(3), .REFRACT_CYCLES(2)) u1 (
        .clk(clk), .reset(reset), .pot_valid(v[1]), .pot_in(pi[1]), .pot_ready(rdy[1]),
        .spk_valid(sv[1]), .spk_out(so[1]), .membrane(mem[1]), .spike_count(cnt[1]));
    lif_spike_generator #(.THRESHOLD(8'd128), .LEAK_SHIFT(3), .REFRACT_CYCLES(0)) u2 (
        .clk(clk), .reset(reset), .pot_valid(v[2]), .pot_in(pi[2]), .pot_ready(rdy[2]),
        .spk_valid(sv[2]), .spk_out(so[2]), .membrane(mem[2]), .spike_count(cnt[2]));

    int total = 0;
    int bad = 0;
    int sends[3] = '{0, 0, 0};
    int pulses[3] = '{0, 0, 0};
    int m_mem[3], m_ref[3], m_cnt[3];
    int thr[3] = '{128, 255, 128};
    int rcy[3] = '{2, 2, 0};
    logic [16:0] sb[$];

    // Expected {spk_out, membrane, spike_count} for one accepted sample
    function automatic logic [16:0] model(int d, logic [7:0] p);
        int nx;
        if (m_ref[d] > 0) begin
            m_ref[d]--;
            m_mem[d] = 0;
            return {1'b0, 8'd0, 8'(m_cnt[d])};
        end
        nx = m_mem[d] - (m_mem[d] >> 3) + int'(p);
        if (nx > 255) nx = 255;
        if (nx >= thr[d]) begin
            m_mem[d] = 0;
            if (m_cnt[d] < 255) m_cnt[d]++;
            m_ref[d] = rcy[d];
            return {1'b1, 8'd0, 8'(m_cnt[d])};
        end
        m_mem[d] = nx;
        return {1'b0, 8'(nx), 8'(m_cnt[d])};
    endfunction

    task automatic model_reset;
        for (int d = 0; d < 3; d++) begin
            m_mem[d] = 0;
            m_ref[d] = 0;
            m_cnt[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                if (sv[d]) pulses[d]++;
                if (sv[d] === 1'b0 && so[d] !== 1'b0) begin
                    total++;
                    bad++;
                    $display("FAIL spk_out_idle dut%0d: spk_out=%b while spk_valid=0, required 0", d, so[d]);
                end
            end
        end
    end

    task automatic send(input int d, input logic [7:0] p, input logic [16:0] e);
        int t;
        logic [16:0] x;
        t = 0;
        while (rdy[d] !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (rdy[d] !== 1'b1) begin
            bad++;
            $display("FAIL ready_wait dut%0d: pot_ready=%b, required 1 within 20 cycles", d, rdy[d]);
            return;
        end
        sb.push_back(e);
        sends[d]++;
        v[d] = 1'b1;
        pi[d] = p;
        @(negedge clk);
        v[d] = 1'b0;
        pi[d] = 8'($urandom);
        total++;
        if (sv[d] !== 1'b0) begin
            bad++;
            $display("FAIL early_valid dut%0d: spk_valid=%b at N+1, required 0", d, sv[d]);
        end
        @(negedge clk);
        total++;
        if (sv[d] !== 1'b1) begin
            bad++;
            $display("FAIL latency dut%0d: spk_valid=%b at N+2, required 1", d, sv[d]);
            void'(sb.pop_front());
        end else begin
            x = sb.pop_front();
            total++;
            if ({so[d], mem[d], cnt[d]} !== x) begin
                bad++;
                $display("FAIL result dut%0d pot_in=%0d: spk=%b mem=%0d cnt=%0d, required spk=%b mem=%0d cnt=%0d",
                         d, p, so[d], mem[d], cnt[d], x[16], x[15:8], x[7:0]);
            end
        end
    endtask

    task automatic send_lit(input int d, input logic [7:0] p, input logic [16:0] e);
        void'(model(d, p));
        send(d, p, e);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            v[d] = 1'b0;
            pi[d] = 8'd0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({rdy[d], sv[d], so[d], mem[d], cnt[d]} !== 19'd0) begin
                bad++;
                $display("FAIL reset_state dut%0d: rdy=%b sv=%b so=%b mem=%0d cnt=%0d, required all 0",
                         d, rdy[d], sv[d], so[d], mem[d], cnt[d]);
            end
        end
        reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (rdy[d] !== 1'b1) begin
                bad++;
                $display("FAIL ready_after_reset dut%0d: pot_ready=%b, required 1", d, rdy[d]);
            end
        end
        model_reset();
    endtask

    task automatic test_integrate_and_refract;
        send_lit(0, 8'd100, {1'b0, 8'd100, 8'd0});
        send_lit(0, 8'd50,  {1'b1, 8'd0,   8'd1});
        send_lit(0, 8'd255, {1'b0, 8'd0,   8'd1});
        send_lit(0, 8'd255, {1'b0, 8'd0,   8'd1});
        send_lit(0, 8'd255, {1'b1, 8'd0,   8'd2});
    endtask

    task automatic test_saturate;
        send_lit(1, 8'd254, {1'b0, 8'd254, 8'd0});
        send_lit(1, 8'd0,   {1'b0, 8'd223, 8'd0});
        send_lit(1, 8'd200, {1'b1, 8'd0,   8'd1});
    endtask

    task automatic test_back_to_back;
        int xfers;
        logic [16:0] x;
        xfers = 0;
        for (int i = 0; i < 13; i++) begin
            if (sv[2] === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra_pulse cycle %0d: spk_valid=1, required no pulse", i);
                end else begin
                    x = sb.pop_front();
                    if ({so[2], mem[2], cnt[2]} !== x) begin
                        bad++;
                        $display("FAIL b2b_result cycle %0d: spk=%b mem=%0d cnt=%0d, required spk=%b mem=%0d cnt=%0d",
                                 i, so[2], mem[2], cnt[2], x[16], x[15:8], x[7:0]);
                    end
                end
            end
            if (i < 10) begin
                total++;
                if (rdy[2] !== (i % 2 == 0)) begin
                    bad++;
                    $display("FAIL b2b_ready cycle %0d: pot_ready=%b, required %0d", i, rdy[2], (i % 2 == 0));
                end
            end
            v[2] = (i < 10);
            pi[2] = 8'd60;
            if (v[2] && rdy[2] === 1'b1) begin
                xfers++;
                sends[2]++;
                sb.push_back(model(2, 8'd60));
            end
            @(negedge clk);
            v[2] = 1'b0;
        end
        total++;
        if (xfers != 5 || sb.size() != 0) begin
            bad++;
            $display("FAIL b2b_count: transfers=%0d pending=%0d, required 5 and 0", xfers, sb.size());
        end
    endtask

    task automatic test_random;
        logic [7:0] p;
        for (int i = 0; i < 24; i++) begin
            p = 8'($urandom_range(0, 255));
            send(0, p, model(0, p));
        end
        send(2, 8'd0, model(2, 8'd0));
    endtask

    task automatic test_reset_mid_update;
        v[0] = 1'b1;
        pi[0] = 8'd200;
        @(negedge clk);
        v[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (sv[0] !== 1'b0 || mem[0] !== 8'd0 || rdy[0] !== 1'b0 || cnt[0] !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid: sv=%b mem=%0d rdy=%b cnt=%0d, required 0 0 0 0", sv[0], mem[0], rdy[0], cnt[0]);
        end
        reset = 1'b0;
        #1;
        total++;
        if (rdy[0] !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_ready: pot_ready=%b, required 1", rdy[0]);
        end
        model_reset();
        repeat (3) @(negedge clk);
        send(0, 8'd100, model(0, 8'd100));
    endtask

    initial begin
        test_reset();
        test_integrate_and_refract();
        test_saturate();
        test_back_to_back();
        test_random();
        test_reset_mid_update();
        repeat (4) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (pulses[d] != sends[d]) begin
                bad++;
                $display("FAIL pulse_count dut%0d: spk_valid pulses=%0d, required %0d", d, pulses[d], sends[d]);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lif_spike_generator.md
LIF_SPIKE_GENERATOR -- requirements
Module: lif_spike_generator

Interface
REQ-001 Parameter THRESHOLD, default 8'd128, is the firing threshold; legal range 1..255.
REQ-002 Parameter LEAK_SHIFT, default 3, is the leak divisor exponent; legal range 0..7, where 0 disables leak.
REQ-003 Parameter REFRACT_CYCLES, default 2, is the number of samples discarded after a spike; legal range 0..15.
REQ-004 Port clk, input, 1 bit, is the clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit, is the synchronous, active-high reset.
REQ-006 Port pot_valid, input, 1 bit, marks pot_in as valid.
REQ-007 Port pot_in, input, 8 bits, is the accumulated synaptic potential for one timestep (unsigned, saturated upstream).
REQ-008 Port pot_ready, output, 1 bit, indicates the block can accept a sample.
REQ-009 Port spk_valid, output, 1 bit, is a one-cycle strobe marking a timestep result.
REQ-010 Port spk_out, output, 1 bit, is the spike for that timestep; it is meaningful only while spk_valid=1 and is 0 otherwise.
REQ-011 Port membrane, output, 8 bits, is the current membrane potential register.
REQ-012 Port spike_count, output, 8 bits, is the saturating count of spikes emitted since reset.

Function
REQ-013 States: IDLE, UPDATE, REFRACT, DRAIN; the state register SHALL be the only source of pot_ready.
REQ-014 pot_ready SHALL be 1 in IDLE and REFRACT, and 0 in UPDATE and DRAIN.
REQ-015 A transfer occurs when pot_valid=1 and pot_ready=1 in the same cycle; pot_valid while pot_ready=0 SHALL be ignored, and the source holds the data.
REQ-016 Transfer in IDLE: latch pot_in into the sample register and move to UPDATE.
REQ-017 Transfer in REFRACT: discard pot_in and move to DRAIN.
REQ-018 In UPDATE, compute next = membrane - (membrane >> LEAK_SHIFT) + sample at 9-bit width (LEAK_SHIFT=0: next = membrane + sample), then saturate to 255 if bit 8 is set.
REQ-019 In UPDATE, if the saturated next >= THRESHOLD: set membrane to 0, register spk_valid=1 and spk_out=1, increment spike_count (holding at 255), and go to REFRACT with the counter loaded to REFRACT_CYCLES; if REFRACT_CYCLES=0, go to IDLE instead.
REQ-020 In UPDATE, otherwise: set membrane to the saturated next, register spk_valid=1 and spk_out=0, and go to IDLE.
REQ-021 In DRAIN: hold membrane at 0, register spk_valid=1 and spk_out=0, and decrement the counter; if the counter is now 0, go to IDLE, else go to REFRACT.
REQ-022 Latency: a transfer in cycle N SHALL produce spk_valid=1 in cycle N+2 only; peak throughput is one sample per 2 cycles.
REQ-023 spk_valid and spk_out SHALL be registered outputs, high for exactly one cycle per accepted sample; there SHALL be no other spk_valid pulses.
REQ-024 REFRACT with no pot_valid SHALL hold indefinitely; the refractory period counts samples, not clocks.
REQ-025 Membrane arithmetic SHALL never wrap; leak at membrane=0 SHALL yield 0.

Reset
REQ-026 While reset=1, on every clock: state=IDLE, membrane=0, sample=0, refractory counter=0, spike_count=0, spk_valid=0, spk_out=0; pot_ready SHALL read 0 during reset.
REQ-027 Reset SHALL take priority over any transfer in the same cycle; a sample in UPDATE or DRAIN SHALL be dropped with no spk_valid.
REQ-028 pot_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-029 Reset, then transfer pot_in=100 -> cycle N+2: spk_valid=1, spk_out=0, membrane=100, spike_count=0.
REQ-030 Continue with pot_in=50 (100-12+50=138) -> spk_valid=1, spk_out=1, membrane=0, spike_count=1, state REFRACT.
REQ-031 Three transfers of 255 after that spike -> first two: spk_out=0, membrane stays 0; third: 0+255 -> spk_out=1, spike_count=2.
REQ-032 THRESHOLD=255: pot_in=254 -> membrane 254, no spike; then pot_in=0 -> membrane 223; then pot_in=200 -> 223-27+200=396 saturates to 255 -> spike, membrane 0.
REQ-033 pot_valid held high for 10 cycles with REFRACT_CYCLES=0 -> exactly 5 transfers, pot_ready toggles 1/0, and 5 spk_valid pulses.
REQ-034 Assert reset in the UPDATE cycle -> no spk_valid follows, membrane=0, and pot_ready=1 in the first cycle after release.
